// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding, operation codes and width for the adder-subtractor sequencer
package addsub_pkg;

    localparam int ADDSUB_WIDTH = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // IDLE doubles as the "waiting for operand A" state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GET_B = 2'd1,
        EXEC  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/addsub_operand_sequencer.sv
// addsub_operand_sequencer: collects A then B+op over a nibble bus, feeds the external
// adder-subtractor and holds its result until accepted.
// Optional macro ADDSUB_SEQ_SIGN_EN adds res_neg, flagging a subtract whose B exceeded A.
module addsub_operand_sequencer
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             din_op,
    output logic             din_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ctrl,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    output logic [WIDTH-1:0] res,
    output logic             res_cout,
`ifdef ADDSUB_SEQ_SIGN_EN
    output logic             res_neg,
`endif
    output logic             res_valid,
    input  logic             res_ready
);

    state_t state;

    // Operand beats are only taken while collecting A or B
    always_comb din_ready = (state == IDLE) || (state == GET_B);

    // Sequencer FSM with operand and result registers; clr overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            add_a     <= '0;
            add_b     <= '0;
            add_ctrl  <= OP_ADD;
            res       <= '0;
            res_cout  <= 1'b0;
            res_valid <= 1'b0;
`ifdef ADDSUB_SEQ_SIGN_EN
            res_neg   <= 1'b0;
`endif
        end else if (clr) begin
            state     <= IDLE;
            res_valid <= 1'b0;
`ifdef ADDSUB_SEQ_SIGN_EN
            res_neg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (din_valid) begin
                    add_a <= din;
                    state <= GET_B;
                end
                GET_B: if (din_valid) begin
                    add_b    <= din;
                    add_ctrl <= din_op;
                    state    <= EXEC;
                end
                EXEC: begin
                    res       <= add_s;
                    res_cout  <= add_cout;
                    res_valid <= 1'b1;
`ifdef ADDSUB_SEQ_SIGN_EN
                    res_neg   <= (add_ctrl == OP_SUB) && (add_b > add_a);
`endif
                    state     <= HOLD;
                end
                HOLD: if (res_ready) begin
                    res_valid <= 1'b0;
`ifdef ADDSUB_SEQ_SIGN_EN
                    res_neg   <= 1'b0;
`endif
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_operand_sequencer.sv
// tb_addsub_operand_sequencer: directed self-checking bench with a behavioural adder-subtractor
module tb_addsub_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic       din_op = 1'b0;
    logic       din_ready;
    logic [3:0] add_a, add_b, add_s, res;
    logic       add_ctrl, add_cout, res_cout, res_valid;
    logic       res_ready = 1'b0;
`ifdef ADDSUB_SEQ_SIGN_EN
    logic       res_neg;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Downstream adder-subtractor: add gives {cout,s}=a+b, subtract gives |a-b| with cout 0
    always_comb begin
        add_s    = '0;
        add_cout = 1'b0;
        if (add_ctrl) add_s = (add_a > add_b) ? add_a - add_b : add_b - add_a;
        else {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};
    end

    addsub_operand_sequencer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .din(din), .din_valid(din_valid), .din_op(din_op), .din_ready(din_ready),
        .add_a(add_a), .add_b(add_b), .add_ctrl(add_ctrl),
        .add_s(add_s), .add_cout(add_cout),
        .res(res), .res_cout(res_cout),
`ifdef ADDSUB_SEQ_SIGN_EN
        .res_neg(res_neg),
`endif
        .res_valid(res_valid), .res_ready(res_ready)
    );

    task automatic test_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({res_valid, din_ready, add_a, add_b, add_ctrl, res, res_cout} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b a=%h b=%h ctrl=%b res=%h cout=%b, want 0 1 0 0 0 0 0",
                     res_valid, din_ready, add_a, add_b, add_ctrl, res, res_cout);
        end
    endtask

    // Runs A, B+op and checks operands, latency and result; leaves the result held
    task automatic run_op(input string name, input logic [3:0] a, input logic [3:0] b, input logic op,
                          input logic [3:0] er, input logic ec, input logic en);
        @(negedge clk);
        din = a; din_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (add_a !== a || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s A beat: add_a=%h ready=%b, want %h 1", name, add_a, din_ready, a);
        end
        din = b; din_op = op;
        @(negedge clk);
        din_valid = 1'b0;
        checks++;
        if (add_b !== b || add_ctrl !== op || res_valid !== 1'b0 || din_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s EXEC: b=%h ctrl=%b valid=%b ready=%b, want %h %b 0 0",
                     name, add_b, add_ctrl, res_valid, din_ready, b, op);
        end
        @(negedge clk);
        checks++;
        if (res !== er || res_cout !== ec || res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s result: res=%h cout=%b valid=%b, want %h %b 1", name, res, res_cout, res_valid, er, ec);
        end
`ifdef ADDSUB_SEQ_SIGN_EN
        checks++;
        if (res_neg !== en) begin
            errors++;
            $display("FAIL %s res_neg: got %b want %b", name, res_neg, en);
        end
`else
        if (en) begin end
`endif
    endtask

    task automatic accept(input string name);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: valid=%b ready=%b, want 0 1", name, res_valid, din_ready);
        end
    endtask

    task automatic test_add();
        run_op("add5p3", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b0);
        accept("add5p3");
        run_op("add9p9", 4'd9, 4'd9, 1'b0, 4'd2, 1'b1, 1'b0);
        accept("add9p9");
        checks++;
        if (res !== 4'd2 || res_cout !== 1'b1) begin
            errors++;
            $display("FAIL retain after accept: res=%h cout=%b, want 2 1", res, res_cout);
        end
    endtask

    task automatic test_sub();
        run_op("sub3m7", 4'd3, 4'd7, 1'b1, 4'd4, 1'b0, 1'b1);
        accept("sub3m7");
        run_op("sub7m3", 4'd7, 4'd3, 1'b1, 4'd4, 1'b0, 1'b0);
        accept("sub7m3");
        run_op("sub6m6", 4'd6, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        accept("sub6m6");
    endtask

    task automatic test_backpressure();
        run_op("bp", 4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b0);
        din = 4'hF; din_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (res !== 4'd8 || res_valid !== 1'b1 || din_ready !== 1'b0 || add_a !== 4'd5 || add_b !== 4'd3) begin
                errors++;
                $display("FAIL backpressure cycle %0d: res=%h valid=%b ready=%b a=%h b=%h, want 8 1 0 5 3",
                         i, res, res_valid, din_ready, add_a, add_b);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        din_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || din_ready !== 1'b1 || add_a !== 4'd5) begin
            errors++;
            $display("FAIL backpressure release: valid=%b ready=%b a=%h, want 0 1 5", res_valid, din_ready, add_a);
        end
    endtask

    task automatic test_clr();
        @(negedge clk);
        din = 4'd4; din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (din_ready !== 1'b1 || add_a !== 4'd4 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr in GET_B: ready=%b a=%h valid=%b, want 1 4 0", din_ready, add_a, res_valid);
        end
        run_op("clr_then_2p1", 4'd2, 4'd1, 1'b0, 4'd3, 1'b0, 1'b0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || din_ready !== 1'b1 || res !== 4'd3 || add_b !== 4'd1) begin
            errors++;
            $display("FAIL clr in HOLD: valid=%b ready=%b res=%h b=%h, want 0 1 3 1", res_valid, din_ready, res, add_b);
        end
    endtask

    task automatic test_reset_exec();
        @(negedge clk);
        din = 4'd1; din_valid = 1'b1;
        @(negedge clk);
        din = 4'd2;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({res_valid, din_ready, add_a, add_b, add_ctrl, res} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL async reset in EXEC: valid=%b ready=%b a=%h b=%h ctrl=%b res=%h, want 0 1 0 0 0 0",
                     res_valid, din_ready, add_a, add_b, add_ctrl, res);
        end
        @(negedge clk);
        din_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || din_ready !== 1'b1) begin
            errors++;
            $display("FAIL after reset release: valid=%b ready=%b, want 0 1", res_valid, din_ready);
        end
        run_op("post_reset", 4'd6, 4'd5, 1'b0, 4'd11, 1'b0, 1'b0);
        accept("post_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_clr();
        test_reset_exec();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/addsub_operand_sequencer.md
Name: addsub_operand_sequencer

Overview:
Upstream/downstream control stage wrapped around the 4-bit combinational adder-subtractor. It collects operand A, then operand B plus the operation, from a shared nibble bus using a valid/ready handshake. It drives registered operands to the adder-subtractor, captures its sum/difference and carry one cycle later, and holds the result until the consumer accepts it. It is the sequential front end and result register that lets the combinational adder-subtractor sit on a clocked bus.

Parameters:
WIDTH, 4, operand/result width; must equal the adder-subtractor operand width.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns the FSM to IDLE
din  input  WIDTH  operand nibble bus
din_valid  input  1  din holds a valid operand
din_op  input  1  operation, sampled with operand B; 0 = add, 1 = subtract (magnitude)
din_ready  output  1  sequencer accepts a din beat this cycle
add_a  output  WIDTH  registered operand A to adder-subtractor
add_b  output  WIDTH  registered operand B to adder-subtractor
add_ctrl  output  1  registered operation to adder-subtractor
add_s  input  WIDTH  adder-subtractor sum/difference
add_cout  input  1  adder-subtractor carry
res  output  WIDTH  captured result
res_cout  output  1  captured carry
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous assert and active-low; the design leaves reset synchronously. On reset: state = IDLE; add_a, add_b, add_ctrl, res and res_cout are 0; res_valid = 0; din_ready = 1 (combinational from IDLE).
- Handshake: a beat transfers when din_valid & din_ready at a rising edge. A result transfers when res_valid & res_ready.
- State GET_A:
  - Encoded as IDLE. din_ready = 1.
  - On a transfer: add_a <= din; go to GET_B.
- State GET_B:
  - din_ready = 1.
  - On a transfer: add_b <= din and add_ctrl <= din_op; go to EXEC.
- State EXEC:
  - din_ready = 0.
  - Exactly one cycle, which lets the adder-subtractor settle.
  - At the end of the cycle: res <= add_s, res_cout <= add_cout, res_valid <= 1; go to HOLD.
- State HOLD:
  - din_ready = 0.
  - res, res_cout and res_valid are held stable until res_ready.
  - On accept: res_valid <= 0; go to IDLE.
  - res and res_cout retain their last values after the accept.
- Latency: 2 clock cycles from the B beat to res_valid = 1.
- Throughput: at most one operation per 4 cycles. Back-to-back operation needs res_ready held high.
- Expected results from the downstream adder-subtractor (the bench models this):
  - add: {cout, s} = a + b.
  - subtract: s = |a − b| and cout = 0.
  - a == b in subtract gives 0.
- clr:
  - Takes priority over every transition.
  - Next state is IDLE and res_valid <= 0.
  - add_a, add_b, add_ctrl, res and res_cout are unchanged.
- Simultaneous din_valid in EXEC or HOLD: the beat is ignored because din_ready = 0. The producer keeps din_valid high.
- Reset mid-operation aborts immediately. No partial result is emitted.
- Outputs add_a, add_b and add_ctrl change only on accepted beats.

Optional Feature:
ADDSUB_SEQ_SIGN_EN.
- Defined: adds output res_neg (1 bit).
  - In EXEC: res_neg <= add_ctrl & (add_b > add_a).
  - Reset value 0. Cleared with res_valid on accept and on clr.
- Undefined: the port and register are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package addsub_pkg:
  - state enum (IDLE, GET_B, EXEC, HOLD) with 2-bit encoding;
  - OP_ADD = 1'b0 and OP_SUB = 1'b1;
  - ADDSUB_WIDTH = 4.
- No sub-module. The adder-subtractor is instantiated alongside this block at the top level, not inside it.

Test Plan:
- Reset, then A=5, B=3, op=0 -> 2 cycles after B: res=8, res_cout=0, res_valid=1.
- A=9, B=9, op=0 -> res=2, res_cout=1.
- A=3, B=7, op=1 -> res=4, res_cout=0. Repeat with A=7, B=3 -> res=4. With A=B=6 -> res=0. With ADDSUB_SEQ_SIGN_EN: res_neg = 1, 0, 0 respectively.
- Backpressure: res_ready=0 for 5 cycles while din_valid=1 -> res and res_valid stable, din_ready=0. Then res_ready=1 for 1 cycle -> res_valid=0, IDLE, din_ready=1.
- clr asserted in GET_B after A=4 -> next B beat (B=2) is treated as A. Sequence A=2, B=1, op=0 -> res=3.
- rst_n pulsed low during EXEC (asynchronous, mid-cycle) -> immediately res_valid=0, add_* = 0, state IDLE, din_ready=1.
